// File: rtl/ps2_host_tx_if.sv
// Command-byte request/status bundle between the uC core and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (output tx_start, output tx_data, input tx_busy, input tx_done, input tx_error);
  modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done, output tx_error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10 shifted bits, ACK check, wait for idle bus.
// Outputs are decoded from registered state, so pad enables change on the clock edge and reset releases them at once.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic      clk,
  input  logic      reset,
  ps2_host_tx_if.slave tx,
  input  logic      ps2_clk_in,
  input  logic      ps2_data_in,
  output logic      ps2_clk_oe,
  output logic      ps2_data_oe
);

  localparam int unsigned CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] FILT_MAX = CW'(FILTER_LEN - 1);
  localparam logic [31:0]   INH_MAX  = 32'(INHIBIT_CYCLES);
  localparam logic [31:0]   TO_MAX   = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [9:0]  frame, frame_n;
  logic [3:0]  bit_idx, bit_idx_n;
  logic        cur_bit, cur_bit_n;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]    sync_a, sync_b, filt;
  logic [CW-1:0] filt_cnt [2];
  logic          filt_clk_d;
  logic          fall_clk;

  logic busy, done, error, clk_oe, data_oe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a      <= 2'b11;
      sync_b      <= 2'b11;
      filt        <= 2'b11;
      filt_cnt[0] <= '0;
      filt_cnt[1] <= '0;
      filt_clk_d  <= 1'b1;
    end else begin
      sync_a     <= {ps2_data_in, ps2_clk_in};
      sync_b     <= sync_a;
      filt_clk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (state == S_IDLE) begin
          filt[i]     <= 1'b1;
          filt_cnt[i] <= '0;
        end else if (sync_b[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_MAX) begin
          filt[i]     <= sync_b[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall_clk = filt_clk_d & ~filt[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      frame   <= '0;
      bit_idx <= '0;
      cur_bit <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      frame   <= frame_n;
      bit_idx <= bit_idx_n;
      cur_bit <= cur_bit_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    frame_n   = frame;
    bit_idx_n = bit_idx;
    cur_bit_n = cur_bit;
    clk_oe    = 1'b0;
    data_oe   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;

    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cnt_n     = '0;
        bit_idx_n = '0;
        cur_bit_n = 1'b1;
        if (tx.tx_start) begin
          frame_n = {1'b1, ~^tx.tx_data, tx.tx_data};
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe = 1'b1;
        cnt_n  = cnt + 32'd1;
        // Final inhibit cycle overlaps the start bit so data is low before clk is released.
        if (cnt == INH_MAX) begin
          data_oe   = 1'b1;
          cnt_n     = '0;
          cur_bit_n = 1'b0;
          state_n   = S_REQ;
        end
      end
      S_REQ: begin
        data_oe = 1'b1;
        if (fall_clk) begin
          cur_bit_n = frame[0];
          bit_idx_n = 4'd1;
          state_n   = S_SEND;
        end
      end
      S_SEND: begin
        data_oe = ~cur_bit;
        if (fall_clk) begin
          cur_bit_n = frame[bit_idx];
          bit_idx_n = bit_idx + 4'd1;
          if (bit_idx == 4'd9) state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (fall_clk) begin
          if (!filt[1]) begin
            state_n = S_WAIT_IDLE;
          end else begin
            error   = 1'b1;
            busy    = 1'b0;
            state_n = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (filt[0] && filt[1]) begin
          done    = 1'b1;
          busy    = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (state inside {S_REQ, S_SEND, S_ACK, S_WAIT_IDLE}) begin
      if (cnt != '1) cnt_n = cnt + 32'd1;
      // Timeout overrides any same-cycle ACK or idle detection.
      if (cnt >= TO_MAX) begin
        clk_oe  = 1'b0;
        data_oe = 1'b0;
        done    = 1'b0;
        error   = 1'b1;
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    end
  end

  assign ps2_clk_oe  = clk_oe;
  assign ps2_data_oe = data_oe;
  assign tx.tx_busy  = busy;
  assign tx.tx_done  = done;
  assign tx.tx_error = error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a cycle-scaled PS/2 keyboard model clocks frames out of the host and checks them.
module tb_ps2_host_tx;
  localparam int INH      = 200;
  localparam int TO       = 50000;
  localparam int FLEN     = 4;
  localparam int DEV_HALF = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk, dev_data, glitch;
  logic ps2_clk_oe, ps2_data_oe;
  wire  ps2_clk_in  = ~ps2_clk_oe & dev_clk & ~glitch;
  wire  ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx_if bus();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FLEN)) dut (
    .clk(clk), .reset(reset), .tx(bus),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int dev_rise_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_done)  done_cnt++;
      if (bus.tx_error) err_cnt++;
    end
  end

  // Reference frame: data LSB first, then odd parity (set when the byte has an even number of ones), then stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0), d};
  endfunction

  task automatic start_tx(input logic [7:0] d, output int inh, output int sb);
    inh = 0; sb = 0;
    @(negedge clk);
    bus.tx_data = d; bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    for (int i = 0; i < INH + 100; i++) begin
      if (!ps2_clk_oe) break;
      if (ps2_data_oe) sb++; else inh++;
      @(negedge clk);
    end
  endtask

  task automatic device(input bit do_ack, input int stop_after, output logic [9:0] cap, output bit seen);
    seen = 1'b0; cap = '0; dev_rise_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      if (ps2_clk_in && !ps2_data_in) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (seen) begin
      repeat (DEV_HALF) @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
        dev_clk = 1'b0;
        repeat (DEV_HALF) @(negedge clk);
        dev_clk = 1'b1;
        dev_rise_cnt = k;
        if (k <= 10) cap[k-1] = ps2_data_in;
        if (k == stop_after) break;
        if (k == 10 && do_ack) begin
          repeat (DEV_HALF/2) @(negedge clk);
          dev_data = 1'b0;
          repeat (DEV_HALF/2) @(negedge clk);
        end else if (k < 11) begin
          repeat (DEV_HALF) @(negedge clk);
        end
      end
    end
    dev_clk = 1'b1; dev_data = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.tx_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_total++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_busy, bus.tx_done, bus.tx_error} !== 5'b0)
      $display("FAIL reset_held outputs=%b required=00000", {ps2_clk_oe, ps2_data_oe, bus.tx_busy, bus.tx_done, bus.tx_error});
    else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_total++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_busy, bus.tx_done, bus.tx_error} !== 5'b0)
      $display("FAIL reset_idle outputs=%b required=00000", {ps2_clk_oe, ps2_data_oe, bus.tx_busy, bus.tx_done, bus.tx_error});
    else n_pass++;
  endtask

  task automatic test_send_ed;
    int inh, sb, d0, e0; logic [9:0] cap; bit seen, ok;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED, inh, sb);
    n_total++;
    if (inh !== INH) $display("FAIL inhibit_len got=%0d required=%0d", inh, INH); else n_pass++;
    n_total++;
    if (sb !== 1) $display("FAIL start_bit_overlap got=%0d required=1", sb); else n_pass++;
    device(1'b1, 0, cap, seen);
    n_total++;
    if (!seen) $display("FAIL ed_request_seen got=0 required=1"); else n_pass++;
    n_total++;
    if (cap !== 10'b1_1_11101101) $display("FAIL ed_frame got=%b required=%b", cap, 10'b1_1_11101101); else n_pass++;
    wait_idle(ok);
    n_total++;
    if (!ok) $display("FAIL ed_idle_timeout busy still 1"); else n_pass++;
    n_total++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL ed_pulses done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_parity;
    logic [7:0] bytes [6];
    int inh, sb, d0; logic [9:0] cap; bit seen, ok;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h01;
    for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      start_tx(bytes[i], inh, sb);
      device(1'b1, 0, cap, seen);
      wait_idle(ok);
      n_total++;
      if (cap !== exp_frame(bytes[i]))
        $display("FAIL frame_%02h got=%b required=%b", bytes[i], cap, exp_frame(bytes[i]));
      else n_pass++;
      n_total++;
      if (done_cnt - d0 !== 1) $display("FAIL done_%02h got=%0d required=1", bytes[i], done_cnt - d0); else n_pass++;
    end
  endtask

  task automatic test_timeout;
    int inh, sb, d0, e0, t; bit hit;
    d0 = done_cnt; e0 = err_cnt; t = 0; hit = 1'b0;
    start_tx(8'($urandom_range(0, 255)), inh, sb);
    for (int i = 0; i < TO + 100; i++) begin
      if (bus.tx_error) begin hit = 1'b1; break; end
      t++;
      @(negedge clk);
    end
    n_total++;
    if (!hit || t !== TO) $display("FAIL timeout_delay got=%0d hit=%0b required=%0d", t, hit, TO); else n_pass++;
    n_total++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_busy} !== 3'b000)
      $display("FAIL timeout_release got=%b required=000", {ps2_clk_oe, ps2_data_oe, bus.tx_busy});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
      $display("FAIL timeout_pulses err=%0d done=%0d required 1/0", err_cnt - e0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_nack;
    int inh, sb, d0, e0; logic [9:0] cap; bit seen, ok; logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    d0 = done_cnt; e0 = err_cnt;
    start_tx(d, inh, sb);
    device(1'b0, 0, cap, seen);
    wait_idle(ok);
    n_total++;
    if (!ok || err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
      $display("FAIL nack_pulses idle=%0b err=%0d done=%0d required 1/1/0", ok, err_cnt - e0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int inh, sb, d0, e0; logic [9:0] cap; bit seen, ok;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4, inh, sb);
    fork
      device(1'b1, 0, cap, seen);
      begin
        repeat (100) @(negedge clk);
        bus.tx_data = 8'hAA; bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
      end
    join
    wait_idle(ok);
    n_total++;
    if (cap !== exp_frame(8'hF4)) $display("FAIL b2b_frame got=%b required=%b", cap, exp_frame(8'hF4)); else n_pass++;
    n_total++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL b2b_pulses done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    repeat (100) @(negedge clk);
    n_total++;
    if ({bus.tx_busy, ps2_clk_oe} !== 2'b00)
      $display("FAIL b2b_not_queued busy_clkoe=%b required=00", {bus.tx_busy, ps2_clk_oe});
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int inh, sb, d0, e0; logic [9:0] cap; bit seen, ok;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'($urandom_range(0, 255)), inh, sb);
    device(1'b1, 4, cap, seen);
    n_total++;
    if (bus.tx_busy !== 1'b1) $display("FAIL mid_busy got=%b required=1", bus.tx_busy); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_busy, bus.tx_done, bus.tx_error} !== 5'b0)
      $display("FAIL mid_reset_release got=%b required=00000", {ps2_clk_oe, ps2_data_oe, bus.tx_busy, bus.tx_done, bus.tx_error});
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    n_total++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0)
      $display("FAIL mid_reset_pulses done=%0d err=%0d required 0/0", done_cnt - d0, err_cnt - e0);
    else n_pass++;

    d0 = done_cnt;
    dev_rise_cnt = 0;
    start_tx(8'hFF, inh, sb);
    fork
      device(1'b1, 0, cap, seen);
      begin
        for (int i = 0; i < 5000 && dev_rise_cnt != 3; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        glitch = 1'b1;
        repeat (2) @(negedge clk);
        glitch = 1'b0;
      end
    join
    wait_idle(ok);
    n_total++;
    if (cap !== exp_frame(8'hFF)) $display("FAIL glitch_frame got=%b required=%b", cap, exp_frame(8'hFF)); else n_pass++;
    n_total++;
    if (!ok || done_cnt - d0 !== 1) $display("FAIL post_reset_done idle=%0b done=%0d required 1/1", ok, done_cnt - d0); else n_pass++;
  endtask

  initial begin
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    dev_clk = 1'b1; dev_data = 1'b1; glitch = 1'b0;
    test_reset();
    test_send_ed();
    test_parity();
    test_timeout();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
